// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types for the rotation and vectoring units.
package cordic_pkg;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_ITER  = 2'd2,
    S_SCALE = 2'd3
  } state_t;

  // Fixed-point formats
  localparam int FRAC_XY  = 16;  // x/y are Q16.16
  localparam int FRAC_ANG = 29;  // angles are Q3.29
  localparam int FRAC_K   = 31;  // gain constant is unsigned Q1.31
  localparam int ANGLE_W  = 32;
  localparam int ATAN_N   = 31;
  localparam int IDX_W    = 5;

  // pi/2 in Q3.29
  localparam logic [ANGLE_W-1:0] PI_HALF = 32'h3243F6A9;

  // 1/An, the inverse CORDIC gain, in unsigned Q1.31 (0.6072529350)
  localparam logic [31:0] K_Q31 = 32'h4DBA76D4;

  // atan(2^-i) in Q3.29, i = 0..30
  localparam logic [ANGLE_W-1:0] ATAN_TABLE [0:ATAN_N-1] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000
  };

endpackage

// File: rtl/cordic_rotation_if.sv
// Request/result bundle of the CORDIC rotation unit.
interface cordic_rotation_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         start_rot;
  logic signed [DATA_WIDTH-1:0] x0_rot;
  logic signed [DATA_WIDTH-1:0] y0_rot;
  logic signed [DATA_WIDTH-1:0] theta_rot;
  logic signed [DATA_WIDTH-1:0] x_rot;
  logic signed [DATA_WIDTH-1:0] y_rot;
  logic                         valid_rot;
  logic                         busy;

  // Requester side
  modport master (
    output start_rot, x0_rot, y0_rot, theta_rot,
    input  x_rot, y_rot, valid_rot, busy
  );

  // Rotation unit side
  modport slave (
    input  start_rot, x0_rot, y0_rot, theta_rot,
    output x_rot, y_rot, valid_rot, busy
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of atan(2^-i) in Q3.29.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  output logic [ANGLE_W-1:0] atan_o
);

  // Table read; indices past the table give zero
  always_comb begin
    atan_o = '0;
    if (int'(idx_i) < ATAN_N) begin
      atan_o = ATAN_TABLE[idx_i];
    end
  end

endmodule

// File: rtl/cordic_rotation.sv
// Iterative CORDIC in rotation mode: rotates (x0, y0) by theta.
// One micro-rotation per clock, followed by a single gain-compensation step.
module cordic_rotation
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ITER       = 24
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start_rot,
  input  logic signed [DATA_WIDTH-1:0] x0_rot,
  input  logic signed [DATA_WIDTH-1:0] y0_rot,
  input  logic signed [DATA_WIDTH-1:0] theta_rot,
  output logic signed [DATA_WIDTH-1:0] x_rot,
  output logic signed [DATA_WIDTH-1:0] y_rot,
  output logic                         valid_rot,
  output logic                         busy
);

  // Two guard bits absorb the CORDIC gain (~1.647) plus the sqrt(2) vector growth
  localparam int XW = DATA_WIDTH + 2;
  // Product width of an XW-bit signed value times the 32-bit unsigned gain
  localparam int PW = XW + 33;

  localparam logic signed [DATA_WIDTH-1:0] PH = $signed(DATA_WIDTH'(PI_HALF));

  state_t                  state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d;
  logic signed [XW-1:0]    y_q, y_d;
  logic signed [DATA_WIDTH-1:0] z_q, z_d;
  logic [IDX_W-1:0]        i_q, i_d;
  logic signed [DATA_WIDTH-1:0] xo_q, xo_d;
  logic signed [DATA_WIDTH-1:0] yo_q, yo_d;
  logic                    valid_q, valid_d;

  logic [ANGLE_W-1:0]           atan_w;
  logic signed [DATA_WIDTH-1:0] atan_s;
  logic signed [XW-1:0]         xs, ys;
  logic signed [PW-1:0]         px, py;

  cordic_atan_rom u_atan_rom (
    .idx_i  (i_q),
    .atan_o (atan_w)
  );

  assign atan_s = $signed(DATA_WIDTH'(atan_w));

  // Per-iteration arithmetic shifts
  assign xs = x_q >>> i_q;
  assign ys = y_q >>> i_q;

  // Gain compensation products, consumed in SCALE
  assign px = PW'(x_q) * $signed(PW'(K_Q31));
  assign py = PW'(y_q) * $signed(PW'(K_Q31));

  // Clamp a wide signed value into the DATA_WIDTH signed range
  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    lo = ~hi;
    if (v > hi) begin
      sat = hi[DATA_WIDTH-1:0];
    end else if (v < lo) begin
      sat = lo[DATA_WIDTH-1:0];
    end else begin
      sat = v[DATA_WIDTH-1:0];
    end
  endfunction

  // Next-state and datapath update for the four-state controller
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_rot) begin
          x_d     = XW'(x0_rot);
          y_d     = XW'(y0_rot);
          z_d     = theta_rot;
          i_d     = '0;
          state_d = S_PRE;
        end
      end

      // Quarter-turn pre-rotation brings the residual angle into CORDIC range
      S_PRE: begin
        if (z_q > PH) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = z_q - PH;
        end else if (z_q < -PH) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = z_q + PH;
        end
        i_d     = '0;
        state_d = S_ITER;
      end

      S_ITER: begin
        if (!z_q[DATA_WIDTH-1]) begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_s;
        end else begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_s;
        end
        i_d = i_q + IDX_W'(1);
        if (i_q == IDX_W'(ITER - 1)) begin
          i_d     = '0;
          state_d = S_SCALE;
        end
      end

      S_SCALE: begin
        xo_d    = sat(px >>> FRAC_K);
        yo_d    = sat(py >>> FRAC_K);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, working registers and result registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      valid_q <= valid_d;
    end
  end

  assign x_rot     = xo_q;
  assign y_rot     = yo_q;
  assign valid_rot = valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cordic_rotation.sv
// Bench for cordic_rotation: directed vector table, multi-cycle sequences
// and random rotations checked against a floating-point reference.
module tb_cordic_rotation;

  localparam int DW = 32;
  localparam int IT = 24;

  logic CLK = 1'b0;
  logic RST;

  int checks = 0;
  int errors = 0;

  cordic_rotation_if #(.DATA_WIDTH(DW)) bus();

  cordic_rotation #(.DATA_WIDTH(DW), .ITER(IT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start_rot (bus.start_rot),
    .x0_rot    (bus.x0_rot),
    .y0_rot    (bus.y0_rot),
    .theta_rot (bus.theta_rot),
    .x_rot     (bus.x_rot),
    .y_rot     (bus.y_rot),
    .valid_rot (bus.valid_rot),
    .busy      (bus.busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] x0;
    logic [31:0] y0;
    logic [31:0] th;
    logic [31:0] ex;
    logic [31:0] ey;
    logic [31:0] tx;
    logic [31:0] ty;
  } vec_t;

  vec_t vecs [8];

  task automatic chk_near(input string nm, input logic [31:0] got, input real exp, input real tol);
    real d;
    checks++;
    d = $itor($signed(got)) - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %h (%0d) want %0.2f +/- %0.1f", nm, got, $signed(got), exp, tol);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // Ideal rotation in Q16.16 LSB units, clamped to the 32-bit signed range
  function automatic real clamp(input real v);
    if (v > 2147483647.0) return 2147483647.0;
    if (v < -2147483648.0) return -2147483648.0;
    return v;
  endfunction

  function automatic real ref_x(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] th);
    real a;
    a = $itor($signed(th)) / 536870912.0;
    return clamp($itor($signed(x0)) * $cos(a) - $itor($signed(y0)) * $sin(a));
  endfunction

  function automatic real ref_y(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] th);
    real a;
    a = $itor($signed(th)) / 536870912.0;
    return clamp($itor($signed(x0)) * $sin(a) + $itor($signed(y0)) * $cos(a));
  endfunction

  // Issue one request at a negedge while idle; return results and edges-to-valid
  task automatic run_op(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] th,
                        output logic [31:0] gx, output logic [31:0] gy, output int lat);
    bus.x0_rot    = x0;
    bus.y0_rot    = y0;
    bus.theta_rot = th;
    bus.start_rot = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start_rot = 1'b0;
    lat = 0;
    while (!bus.valid_rot && lat < 200) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    gx = bus.x_rot;
    gy = bus.y_rot;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gx, gy, sx, sy;
    logic [31:0] rx, ry, rth;
    int lat, vcnt, nval;
    int vidx [$];

    vecs[0] = '{32'h00010000, 32'h00000000, 32'h3243F6A9, 32'h00000000, 32'h00010000, 4, 4};
    vecs[1] = '{32'h00030000, 32'h00040000, 32'h00000000, 32'h00030000, 32'h00040000, 4, 4};
    vecs[2] = '{32'h00010000, 32'h00000000, 32'h6487ED51, 32'hFFFF0000, 32'h00000000, 4, 4};
    vecs[3] = '{32'h00010000, 32'h00000000, 32'hCDBC0957, 32'h00000000, 32'hFFFF0000, 4, 4};
    vecs[4] = '{32'h00000000, 32'h00010000, 32'h3243F6A9, 32'hFFFF0000, 32'h00000000, 4, 4};
    vecs[5] = '{32'h00010000, 32'h00000000, 32'hE6DE04AB, 32'h0000B505, 32'hFFFF4AFB, 4, 4};
    vecs[6] = '{32'h80000000, 32'h80000000, 32'h1921FB54, 32'h00000000, 32'h80000000, 2048, 0};
    vecs[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h1921FB54, 32'h00000000, 32'h7FFFFFFF, 2048, 0};

    RST           = 1'b0;
    bus.start_rot = 1'b0;
    bus.x0_rot    = '0;
    bus.y0_rot    = '0;
    bus.theta_rot = '0;
    repeat (3) @(negedge CLK);
    chk_int("reset_x", int'(bus.x_rot), 0);
    chk_int("reset_y", int'(bus.y_rot), 0);
    chk_int("reset_valid", int'(bus.valid_rot), 0);
    chk_int("reset_busy", int'(bus.busy), 0);
    RST = 1'b1;
    @(negedge CLK);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].x0, vecs[i].y0, vecs[i].th, gx, gy, lat);
      chk_int($sformatf("vec%0d_latency", i), lat, IT + 2);
      chk_near($sformatf("vec%0d_x", i), gx, $itor($signed(vecs[i].ex)), $itor(vecs[i].tx));
      chk_near($sformatf("vec%0d_y", i), gy, $itor($signed(vecs[i].ey)), $itor(vecs[i].ty));
      chk_int($sformatf("vec%0d_busy_at_valid", i), int'(bus.busy), 0);
      @(posedge CLK);
      @(negedge CLK);
      chk_int($sformatf("vec%0d_pulse_width", i), int'(bus.valid_rot), 0);
      chk_near($sformatf("vec%0d_hold_x", i), bus.x_rot, $itor($signed(gx)), 0.0);
    end

    // Second start while busy is dropped
    bus.x0_rot = 32'h00020000; bus.y0_rot = 32'h00010000; bus.theta_rot = 32'h0;
    bus.start_rot = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start_rot = 1'b0;
    vcnt = 0;
    for (int c = 1; c <= 70; c++) begin
      if (c == 3) chk_int("ignore_busy_high", int'(bus.busy), 1);
      if (c == 5) begin
        bus.x0_rot = 32'h00050000; bus.y0_rot = 32'h00050000; bus.theta_rot = 32'h1921FB54;
        bus.start_rot = 1'b1;
      end
      if (c == 6) bus.start_rot = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      if (bus.valid_rot) begin
        vcnt++;
        sx = bus.x_rot;
        sy = bus.y_rot;
      end
    end
    chk_int("ignore_valid_count", vcnt, 1);
    chk_near("ignore_x", sx, 131072.0, 4.0);
    chk_near("ignore_y", sy, 65536.0, 4.0);

    // Reset mid-operation
    bus.x0_rot = 32'h00123456; bus.y0_rot = 32'hFFF00000; bus.theta_rot = 32'h10000000;
    bus.start_rot = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.start_rot = 1'b0;
    repeat (9) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    chk_int("midreset_busy_before", int'(bus.busy), 1);
    RST = 1'b0;
    #1;
    chk_int("midreset_x", int'(bus.x_rot), 0);
    chk_int("midreset_y", int'(bus.y_rot), 0);
    chk_int("midreset_valid", int'(bus.valid_rot), 0);
    chk_int("midreset_busy", int'(bus.busy), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    nval = 0;
    repeat (40) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.valid_rot) nval++;
    end
    chk_int("midreset_no_valid", nval, 0);
    run_op(32'h00070000, 32'hFFFD0000, 32'h0, gx, gy, lat);
    chk_int("postreset_latency", lat, IT + 2);
    chk_near("postreset_x", gx, 458752.0, 4.0);
    chk_near("postreset_y", gy, -196608.0, 4.0);

    // Held start: back-to-back operations
    bus.x0_rot = 32'h00010000; bus.y0_rot = 32'h0; bus.theta_rot = 32'hE6DE04AB;
    bus.start_rot = 1'b1;
    for (int c = 0; c < 140; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c == 99) bus.start_rot = 1'b0;
      if (bus.valid_rot) begin
        vidx.push_back(c);
        chk_near($sformatf("held%0d_x", c), bus.x_rot, 46341.0, 4.0);
        chk_near($sformatf("held%0d_y", c), bus.y_rot, -46341.0, 4.0);
      end
    end
    chk_int("held_valid_count", vidx.size(), 4);
    for (int n = 0; n < vidx.size(); n++) begin
      chk_int($sformatf("held_valid_cycle%0d", n), vidx[n], (IT + 2) + n * (IT + 3));
    end

    // Random rotations against the floating-point reference
    for (int n = 0; n < 40; n++) begin
      rx  = 32'($urandom_range(0, 8388608)) - 32'd4194304;
      ry  = 32'($urandom_range(0, 8388608)) - 32'd4194304;
      rth = 32'($urandom_range(0, 32'hC90FDAA2)) - 32'h6487ED51;
      run_op(rx, ry, rth, gx, gy, lat);
      chk_int($sformatf("rand%0d_latency", n), lat, IT + 2);
      chk_near($sformatf("rand%0d_x", n), gx, ref_x(rx, ry, rth), 8.0);
      chk_near($sformatf("rand%0d_y", n), gy, ref_y(rx, ry, rth), 8.0);
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
